// File: rtl/instr_info_pkg.sv
// Shared instruction-buffer types and default fetch/decode widths.
// Used by the instruction FIFO and its frontend/decode neighbours.
package instr_info_pkg;

    localparam int IF_WIDTH_DEFAULT = 2;
    localparam int ID_WIDTH_DEFAULT = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } instr_buffer_info_t;

endpackage

// File: rtl/lead_ones_count.sv
// Length of the run of ones starting at bit 0; purely combinational, no backpressure.
module lead_ones_count #(
    parameter int W = 2
) (
    input  logic [W-1:0]             vec_i,
    output logic [$clog2(W+1)-1:0]   cnt_o
);

    localparam int CNT_W = $clog2(W+1);

    logic run;

    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & vec_i[i];
            if (run) begin
                cnt_o = CNT_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/instr_fifo_multiport.sv
// Multi-lane instruction FIFO between fetch and decode; push visible on outputs one cycle later.
// Frontend is stalled whole-bundle when free space < IF_WIDTH; decode pops by leading accept run.
module instr_fifo_multiport
    import instr_info_pkg::*;
#(
    parameter int IF_WIDTH = IF_WIDTH_DEFAULT,
    parameter int ID_WIDTH = ID_WIDTH_DEFAULT,
    parameter int DEPTH    = 16,
    parameter int AF_SLACK = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  instr_buffer_info_t [IF_WIDTH-1:0]   frontend_instr_i,
    output logic                                frontend_stallreq_o,
    input  logic [ID_WIDTH-1:0]                 backend_accept_i,
    input  logic                                backend_flush_i,
    output instr_buffer_info_t [ID_WIDTH-1:0]   backend_instr_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                empty_o,
    output logic                                full_o,
    output logic                                almost_full_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PUW = $clog2(IF_WIDTH + 1);
    localparam int POW = $clog2(ID_WIDTH + 1);

    instr_buffer_info_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       free_cnt;
    logic [IF_WIDTH-1:0] fe_vld;
    logic [ID_WIDTH-1:0] out_vld;
    logic [ID_WIDTH-1:0] pop_req;
    logic [PUW-1:0]      fe_run;
    logic [PUW-1:0]      npush;
    logic [POW-1:0]      npop;

    assign free_cnt            = CW'(DEPTH) - count_q;
    assign frontend_stallreq_o = int'(free_cnt) < IF_WIDTH;
    assign almost_full_o       = int'(free_cnt) <= AF_SLACK;
    assign empty_o             = (count_q == '0);
    assign full_o              = (count_q == CW'(DEPTH));
    assign count_o             = count_q;

    always_comb begin
        backend_instr_o = '0;
        out_vld         = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            if (i < int'(count_q)) begin
                backend_instr_o[i] = mem_q[rd_ptr_q + PW'(i)];
            end
            out_vld[i] = backend_instr_o[i].valid;
        end
    end

    always_comb begin
        fe_vld = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            fe_vld[i] = frontend_instr_i[i].valid;
        end
    end

    // Only the valid prefix of a bundle is counted; lanes after a gap are dropped.
    lead_ones_count #(.W(IF_WIDTH)) u_push_run (
        .vec_i (fe_vld),
        .cnt_o (fe_run)
    );

    assign npush   = (frontend_stallreq_o || backend_flush_i) ? '0 : fe_run;
    assign pop_req = backend_accept_i & out_vld;

    lead_ones_count #(.W(ID_WIDTH)) u_pop_run (
        .vec_i (pop_req),
        .cnt_o (npop)
    );

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + PW'(npop);
        wr_ptr_d = wr_ptr_q + PW'(npush);
        count_d  = count_q + CW'(npush) - CW'(npop);
        for (int i = 0; i < ID_WIDTH; i++) begin
            if (i < int'(npop)) begin
                mem_d[rd_ptr_q + PW'(i)] = '0;
            end
        end
        // Push targets only free slots, so it never collides with the cleared pop slots.
        for (int i = 0; i < IF_WIDTH; i++) begin
            if (i < int'(npush)) begin
                mem_d[wr_ptr_q + PW'(i)] = frontend_instr_i[i];
            end
        end
        if (backend_flush_i) begin
            mem_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fifo_multiport.sv
// Scoreboard bench for instr_fifo_multiport with default parameters (2 in, 2 out, depth 16).
module tb_instr_fifo_multiport;
    import instr_info_pkg::*;

    localparam int DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    instr_buffer_info_t [1:0]    fe;
    logic                        stall;
    logic [1:0]                  acc;
    logic                        flush;
    instr_buffer_info_t [1:0]    bo;
    logic [4:0]                  cnt;
    logic                        empty, full, af;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb[$];
    logic [31:0] next_pc;
    int          cur_nl;
    logic [1:0]  cur_acc;
    bit          cur_fl;

    always #5 clk = ~clk;

    instr_fifo_multiport #(.IF_WIDTH(2), .ID_WIDTH(2), .DEPTH(DEPTH), .AF_SLACK(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frontend_instr_i    (fe),
        .frontend_stallreq_o (stall),
        .backend_accept_i    (acc),
        .backend_flush_i     (flush),
        .backend_instr_o     (bo),
        .count_o             (cnt),
        .empty_o             (empty),
        .full_o              (full),
        .almost_full_o       (af)
    );

    function automatic bit model_stall();
        return (DEPTH - sb.size()) < 2;
    endfunction

    function automatic int model_npop();
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            if (i < sb.size() && cur_acc[i] && n == i) n++;
        end
        return n;
    endfunction

    function automatic instr_buffer_info_t mk(input logic [31:0] pc);
        instr_buffer_info_t e;
        e.valid = 1'b1;
        e.pc    = pc;
        e.instr = ~pc;
        return e;
    endfunction

    task automatic drive(input int nl, input logic [1:0] a, input bit fl);
        cur_nl  = nl;
        cur_acc = a;
        cur_fl  = fl;
        for (int i = 0; i < 2; i++) begin
            fe[i] = (i < nl) ? mk(next_pc + 32'(4 * i)) : '0;
        end
        acc   = a;
        flush = fl;
    endtask

    // Advances the reference queue the way the clock edge should, then steps one cycle.
    task automatic commit();
        bit st;
        int np;
        st = model_stall();
        np = model_npop();
        if (cur_fl) begin
            sb.delete();
        end else begin
            repeat (np) void'(sb.pop_front());
            if (!st && cur_nl > 0) begin
                for (int i = 0; i < cur_nl; i++) sb.push_back(next_pc + 32'(4 * i));
                next_pc += 32'(4 * cur_nl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 2'b00, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        next_pc = 32'h1000;
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (af !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", af); end
        n_cmp++; if (bo !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", bo); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            drive(2, 2'b00, 1'b0);
            n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fill_stall_%0d: got %b want 0", k, stall); end
            commit();
        end
        n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", cnt); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL fill_stall: got %b want 1", stall); end
        n_cmp++; if (af !== 1'b1) begin n_err++; $display("FAIL fill_af: got %b want 1", af); end
        n_cmp++; if (bo[0] !== mk(32'h1000)) begin n_err++; $display("FAIL fill_lane0: got %h want %h", bo[0], mk(32'h1000)); end
        drive(2, 2'b00, 1'b0);
        commit();
        n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL fill_held_count: got %0d want 16", cnt); end
        n_cmp++; if (bo[1] !== mk(32'h1004)) begin n_err++; $display("FAIL fill_lane1: got %h want %h", bo[1], mk(32'h1004)); end
    endtask

    task automatic test_full_pop_push();
        drive(2, 2'b11, 1'b0);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL fpp_stall: got %b want 1", stall); end
        commit();
        n_cmp++; if (cnt !== 5'd14) begin n_err++; $display("FAIL fpp_count14: got %0d want 14", cnt); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fpp_stall_drop: got %b want 0", stall); end
        n_cmp++; if (bo[0] !== mk(32'h1008)) begin n_err++; $display("FAIL fpp_lane0: got %h want %h", bo[0], mk(32'h1008)); end
        drive(2, 2'b00, 1'b0);
        commit();
        n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL fpp_count16: got %0d want 16", cnt); end
    endtask

    task automatic test_count_one();
        for (int k = 0; k < 20 && sb.size() > 1; k++) begin
            drive(0, (sb.size() >= 3) ? 2'b11 : 2'b01, 1'b0);
            n_cmp++; if (bo[0] !== mk(sb[0])) begin n_err++; $display("FAIL drain_lane0: got %h want %h", bo[0], mk(sb[0])); end
            commit();
        end
        n_cmp++; if (cnt !== 5'd1) begin n_err++; $display("FAIL one_count: got %0d want 1", cnt); end
        drive(0, 2'b10, 1'b0);
        commit();
        n_cmp++; if (cnt !== 5'd1) begin n_err++; $display("FAIL one_gap_accept: got %0d want 1", cnt); end
        drive(0, 2'b11, 1'b0);
        n_cmp++; if (bo[1] !== '0) begin n_err++; $display("FAIL one_lane1_invalid: got %h want 0", bo[1]); end
        n_cmp++; if (bo[0] !== mk(32'h1044)) begin n_err++; $display("FAIL one_lane0: got %h want %h", bo[0], mk(32'h1044)); end
        commit();
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL one_pop_count: got %0d want 0", cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL one_empty: got %b want 1", empty); end
    endtask

    task automatic test_stream();
        int pushed = 0;
        int popped = 0;
        int np;
        int nl;
        for (int cyc = 0; cyc < 400 && !(pushed == 40 && sb.size() == 0); cyc++) begin
            nl = 0;
            if (pushed < 40 && $urandom_range(0, 3) != 0) begin
                nl = (40 - pushed >= 2) ? int'($urandom_range(1, 2)) : 1;
            end
            drive(nl, 2'($urandom_range(0, 3)), 1'b0);
            np = model_npop();
            n_cmp++; if (cnt !== 5'(sb.size())) begin n_err++; $display("FAIL stream_count: got %0d want %0d", cnt, sb.size()); end
            n_cmp++; if (stall !== model_stall()) begin n_err++; $display("FAIL stream_stall: got %b want %b", stall, model_stall()); end
            for (int i = 0; i < np; i++) begin
                n_cmp++;
                if (bo[i] !== mk(sb[i])) begin
                    n_err++; $display("FAIL stream_lane%0d: got %h want %h", i, bo[i], mk(sb[i]));
                end
            end
            if (!model_stall() && nl > 0) pushed += nl;
            popped += np;
            commit();
        end
        n_cmp++; if (popped != 40 || sb.size() != 0) begin n_err++; $display("FAIL stream_done: popped %0d left %0d want 40/0", popped, sb.size()); end
    endtask

    task automatic test_flush();
        drive(2, 2'b00, 1'b0); commit();
        drive(2, 2'b00, 1'b0); commit();
        drive(1, 2'b00, 1'b0); commit();
        n_cmp++; if (cnt !== 5'd5) begin n_err++; $display("FAIL flush_pre_count: got %0d want 5", cnt); end
        drive(2, 2'b11, 1'b1);
        commit();
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", empty); end
        n_cmp++; if (bo !== '0) begin n_err++; $display("FAIL flush_out: got %h want 0", bo); end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 4; k++) begin drive(2, 2'b00, 1'b0); commit(); end
        drive(1, 2'b00, 1'b0); commit();
        n_cmp++; if (cnt !== 5'd9) begin n_err++; $display("FAIL mrst_pre_count: got %0d want 9", cnt); end
        rst = 1'b1;
        drive(2, 2'b11, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        drive(0, 2'b00, 1'b0);
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL mrst_full: got %b want 0", full); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mrst_stall: got %b want 0", stall); end
        n_cmp++; if (af !== 1'b0) begin n_err++; $display("FAIL mrst_af: got %b want 0", af); end
        n_cmp++; if (bo !== '0) begin n_err++; $display("FAIL mrst_out: got %h want 0", bo); end
    endtask

    initial begin
        rst     = 1'b1;
        fe      = '0;
        acc     = 2'b00;
        flush   = 1'b0;
        next_pc = 32'h1000;
        cur_nl  = 0;
        cur_acc = 2'b00;
        cur_fl  = 1'b0;
        test_reset();
        test_fill();
        test_full_pop_push();
        test_count_one();
        test_stream();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
